m92_video_mixer: RTL and testbench
==================================

Name: m92_video_mixer

Overview:
- Downstream of the GA23 tilemap stage and the sprite stage.
- Merges GA23 colour/priority with the sprite pixel and looks the winner up in a CPU-writable 4K x 16 palette RAM.
- Emits 8-bit RGB plus blank/sync signals delayed to stay aligned with the pixel.
- Owns CPU read/write access to palette memory.

Parameters:
- PAL_AW, 12, palette RAM word-address width (4096 entries)
- PIPE_LAT, 2, ce_pix cycles from pixel input to RGB output; fixed, exported for alignment checks only

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ce_pix  in  1  pixel clock enable
- tile_color  in  11  GA23 colour: [10:4] palette, [3:0] pen; pen 0 = transparent
- tile_prio  in  1  GA23 priority bit
- obj_color  in  11  sprite colour; pen 0 = transparent
- pal_bank  in  1  palette bank select (from system I/O latch)
- hblank_in, vblank_in, hsync_in, vsync_in  in  1 each  GA23 timing
- cpu_addr  in  11  CPU palette word address
- cpu_din  in  16  CPU write data
- cpu_wr  in  1  write strobe, one clk
- cpu_rd  in  1  read strobe, one clk
- cpu_dout  out  16  read data
- cpu_ack  out  1  one-clk pulse when an access completes
- dbg_en  in  2  [0] tiles, [1] sprites; used only with MIXER_DBG_EN
- red, green, blue  out  8 each  pixel colour
- hblank, vblank, hsync, vsync  out  1 each  delayed timing

Behaviour:
- All state in the clk domain. Reset is synchronous, active-high, single clock.
- Reset values:
  - red/green/blue = 0, cpu_dout = 0, cpu_ack = 0.
  - hblank = vblank = 1, hsync = vsync = 0.
  - Pipeline registers cleared.
  - Palette contents are not cleared.
- Stage 0 (ce_pix), select. Let t_op = tile_color[3:0] != 0 and o_op = obj_color[3:0] != 0.
  - tile_prio & t_op: tile wins.
  - else o_op: sprite wins.
  - else: tile wins (pen 0 passes through, giving the backdrop).
  - Index = {pal_bank, winner_is_obj, winner_color[9:0]}, 12 bits.
- Stage 1 (ce_pix): synchronous read, video port A, registered palette word.
- Stage 2 (ce_pix): expand xBBBBBGGGGGRRRRR to 8 bits by replication, e.g. red = {R, R[4:2]}.
  - If delayed hblank|vblank, force RGB to 0.
- Timing inputs pass through a 2-deep shift register clocked on ce_pix. Total latency is exactly 2 ce_pix enables for RGB and timing alike.
- No ce_pix: every pipeline stage holds.
- CPU port B runs every clk, independent of ce_pix. CPU address = {pal_bank, cpu_addr}.
- Write: RAM updated on the strobe edge; cpu_ack = 1 the following clk.
- Read: cpu_dout valid and cpu_ack = 1 the clk after the strobe; cpu_dout holds until the next read.
- cpu_wr and cpu_rd together: write performed, read ignored, one ack, cpu_dout unchanged.
- Strobe in the clk right after a previous strobe: accepted. There is no busy state; throughput is 1 access/clk.
- Video read and CPU write to the same address in the same clk: video gets the old data (read-before-write).
- Reset asserted mid CPU access: the ack is suppressed. A write already on the RAM edge stands.

Optional Feature:
- Macro MIXER_DBG_EN.
- Defined: dbg_en[0]=0 treats the tile pen as 0; dbg_en[1]=0 treats the sprite pen as 0. Both apply before stage-0 selection.
- Undefined: dbg_en is ignored. The selection logic and latency are identical either way.

Decomposition:
- Package m92_video_pkg:
  - typedef pal_word_t (16-bit packed x/B/G/R)
  - function expand5to8
  - constants PAL_AW and PIPE_LAT
  - localparam TRANSPARENT_PEN = 4'd0
- Sub-module m92_palette_ram: true dual-port 4K x 16, both ports synchronous read, read-before-write. It keeps the BRAM inference separate from the mixing logic.

Test Plan:
- Write 0x7FFF at CPU 0x123 (pal_bank=0), then read it back -> cpu_ack one clk after each strobe; cpu_dout = 0x7FFF.
- Palette 0x0A5 = 0x001F, tile_color 0x0A5, tile_prio 0, obj pen 0, blanks low, ce_pix every clk -> red = 0xFF, green = blue = 0 exactly 2 ce_pix later.
- Tile 0x0A5 with prio 0 plus obj 0x013 (palette 0x413 = 0x7C00) -> sprite wins: blue = 0xFF. Set tile_prio=1 -> tile wins, red = 0xFF.
- Drive hblank_in high for one pixel -> hblank high and RGB = 0 on exactly that pixel, 2 ce_pix later.
- ce_pix low for 5 clks mid-line -> outputs frozen. Meanwhile a CPU write to the displayed entry -> new colour appears at most 2 ce_pix after ce_pix resumes.
- With MIXER_DBG_EN and dbg_en = 2'b01 -> sprite ignored, tile colour shown. Reset mid-line -> RGB = 0 and hblank = 1 on the next clk.

Source files
------------

// File: rtl/m92_video_pkg.sv
`default_nettype none
// ============================================================================
// Module   : m92_video_pkg
// Purpose  : Shared types, constants and colour helper for the M92 video mixer.
// Revision : 1.0 - initial release
// ============================================================================
package m92_video_pkg;

    localparam int PAL_AW = 12;
    localparam int PIPE_LAT = 2;
    localparam logic [3:0] TRANSPARENT_PEN = 4'd0;

    typedef struct packed {
        logic       x;
        logic [4:0] b;
        logic [4:0] g;
        logic [4:0] r;
    } pal_word_t;

    // Replicating the top bits makes 5'h1F map to 8'hFF and 5'h00 to 8'h00.
    function automatic logic [7:0] expand5to8(input logic [4:0] v);
        return {v, v[4:2]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/m92_palette_ram.sv
`default_nettype none
// ============================================================================
// Module   : m92_palette_ram
// Purpose  : Dual-port palette RAM, synchronous read on both ports,
//            read-before-write. Port A is the video read port, port B the CPU.
// Revision : 1.0 - initial release
// ============================================================================
module m92_palette_ram #(
    parameter int AW = 12,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_a_en,
    input  logic [AW-1:0] i_a_addr,
    output logic [DW-1:0] o_a_dout,
    input  logic          i_b_we,
    input  logic          i_b_re,
    input  logic [AW-1:0] i_b_addr,
    input  logic [DW-1:0] i_b_din,
    output logic [DW-1:0] o_b_dout
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_a_dout_q;
    logic [DW-1:0] r_b_dout_q;

    // Output registers take reset; the array itself is never cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_dout_q <= '0;
        end else if (i_a_en) begin
            r_a_dout_q <= r_mem[i_a_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (i_b_we) begin
            r_mem[i_b_addr] <= i_b_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_b_dout_q <= '0;
        end else if (i_b_re) begin
            r_b_dout_q <= r_mem[i_b_addr];
        end
    end

    assign o_a_dout = r_a_dout_q;
    assign o_b_dout = r_b_dout_q;

endmodule
`default_nettype wire

// File: rtl/m92_video_mixer.sv
`default_nettype none
// ============================================================================
// Module   : m92_video_mixer
// Purpose  : Tile/sprite priority mix, palette lookup and RGB888 expansion with
//            aligned blank/sync. Optional macro MIXER_DBG_EN enables per-layer
//            masking through dbg_en.
// Revision : 1.0 - initial release
// ============================================================================
module m92_video_mixer #(
    parameter int PAL_AW   = m92_video_pkg::PAL_AW,
    parameter int PIPE_LAT = m92_video_pkg::PIPE_LAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_pix,
    input  logic [10:0] tile_color,
    input  logic        tile_prio,
    input  logic [10:0] obj_color,
    input  logic        pal_bank,
    input  logic        hblank_in,
    input  logic        vblank_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [10:0] cpu_addr,
    input  logic [15:0] cpu_din,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    output logic [15:0] cpu_dout,
    output logic        cpu_ack,
    input  logic [1:0]  dbg_en,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        hblank,
    output logic        vblank,
    output logic        hsync,
    output logic        vsync
);

    import m92_video_pkg::*;

    // Timing bits packed as {hblank, vblank, hsync, vsync}.
    localparam logic [3:0] c_TMG_RST = 4'b1100;

    logic [10:0]                 w_tile_c;
    logic [10:0]                 w_obj_c;
    logic [10:0]                 w_win_c;
    logic                        w_obj_win;
    logic [PAL_AW-1:0]           w_vid_idx;
    pal_word_t                   w_pal_word;
    logic                        w_blank_s1;
    logic                        w_unused;

    logic [PIPE_LAT-1:0][3:0]    r_tmg_q, w_tmg_d;
    logic [7:0]                  r_red_q, w_red_d;
    logic [7:0]                  r_green_q, w_green_d;
    logic [7:0]                  r_blue_q, w_blue_d;
    logic                        r_cpu_ack_q, w_cpu_ack_d;

    always_comb begin
        w_tile_c = tile_color;
        w_obj_c  = obj_color;
`ifdef MIXER_DBG_EN
        if (!dbg_en[0]) w_tile_c[3:0] = TRANSPARENT_PEN;
        if (!dbg_en[1]) w_obj_c[3:0]  = TRANSPARENT_PEN;
`endif
        // Priority tile beats sprite; an all-transparent pixel falls back to
        // the tile so its pen-0 entry becomes the backdrop.
        w_obj_win = 1'b0;
        if (tile_prio && (w_tile_c[3:0] != TRANSPARENT_PEN)) begin
            w_obj_win = 1'b0;
        end else if (w_obj_c[3:0] != TRANSPARENT_PEN) begin
            w_obj_win = 1'b1;
        end
        w_win_c   = w_obj_win ? w_obj_c : w_tile_c;
        w_vid_idx = {pal_bank, w_obj_win, w_win_c[9:0]};
    end

`ifdef MIXER_DBG_EN
    assign w_unused = w_win_c[10] ^ w_pal_word.x;
`else
    assign w_unused = w_win_c[10] ^ w_pal_word.x ^ (^dbg_en);
`endif

    m92_palette_ram #(
        .AW (PAL_AW),
        .DW (16)
    ) u_palette_ram (
        .clk      (clk),
        .rst      (reset),
        .i_a_en   (ce_pix),
        .i_a_addr (w_vid_idx),
        .o_a_dout (w_pal_word),
        .i_b_we   (cpu_wr),
        .i_b_re   (cpu_rd & ~cpu_wr),
        .i_b_addr ({pal_bank, cpu_addr}),
        .i_b_din  (cpu_din),
        .o_b_dout (cpu_dout)
    );

    // Stage PIPE_LAT-2 of the timing chain is captured alongside the palette word.
    always_comb begin
        w_tmg_d     = r_tmg_q;
        w_red_d     = r_red_q;
        w_green_d   = r_green_q;
        w_blue_d    = r_blue_q;
        w_blank_s1  = r_tmg_q[PIPE_LAT-2][3] | r_tmg_q[PIPE_LAT-2][2];
        w_cpu_ack_d = cpu_wr | cpu_rd;
        if (ce_pix) begin
            w_tmg_d = {r_tmg_q[PIPE_LAT-2:0], {hblank_in, vblank_in, hsync_in, vsync_in}};
            if (w_blank_s1) begin
                w_red_d   = 8'd0;
                w_green_d = 8'd0;
                w_blue_d  = 8'd0;
            end else begin
                w_red_d   = expand5to8(w_pal_word.r);
                w_green_d = expand5to8(w_pal_word.g);
                w_blue_d  = expand5to8(w_pal_word.b);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmg_q     <= {PIPE_LAT{c_TMG_RST}};
            r_red_q     <= 8'd0;
            r_green_q   <= 8'd0;
            r_blue_q    <= 8'd0;
            r_cpu_ack_q <= 1'b0;
        end else begin
            r_tmg_q     <= w_tmg_d;
            r_red_q     <= w_red_d;
            r_green_q   <= w_green_d;
            r_blue_q    <= w_blue_d;
            r_cpu_ack_q <= w_cpu_ack_d;
        end
    end

    assign red     = r_red_q;
    assign green   = r_green_q;
    assign blue    = r_blue_q;
    assign hblank  = r_tmg_q[PIPE_LAT-1][3];
    assign vblank  = r_tmg_q[PIPE_LAT-1][2];
    assign hsync   = r_tmg_q[PIPE_LAT-1][1];
    assign vsync   = r_tmg_q[PIPE_LAT-1][0];
    assign cpu_ack = r_cpu_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_m92_video_mixer.sv
`default_nettype none
// ============================================================================
// Module   : tb_m92_video_mixer
// Purpose  : Scoreboard bench for m92_video_mixer: directed palette/priority
//            cases followed by randomized traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_m92_video_mixer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce_pix = 1'b0;
    logic [10:0] tile_color = '0;
    logic        tile_prio = 1'b0;
    logic [10:0] obj_color = '0;
    logic        pal_bank = 1'b0;
    logic        hblank_in = 1'b0, vblank_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
    logic [10:0] cpu_addr = '0;
    logic [15:0] cpu_din = '0;
    logic        cpu_wr = 1'b0, cpu_rd = 1'b0;
    logic [15:0] cpu_dout;
    logic        cpu_ack;
    logic [1:0]  dbg_en = 2'b11;
    logic [7:0]  red, green, blue;
    logic        hblank, vblank, hsync, vsync;

    always #5 clk = ~clk;

    m92_video_mixer dut (
        .clk(clk), .reset(reset), .ce_pix(ce_pix),
        .tile_color(tile_color), .tile_prio(tile_prio), .obj_color(obj_color),
        .pal_bank(pal_bank),
        .hblank_in(hblank_in), .vblank_in(vblank_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .dbg_en(dbg_en),
        .red(red), .green(green), .blue(blue),
        .hblank(hblank), .vblank(vblank), .hsync(hsync), .vsync(vsync)
    );

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       hb;
        logic       vb;
        logic       hs;
        logic       vs;
    } pix_t;

    localparam pix_t RST_EXP = '{r: 8'h00, g: 8'h00, b: 8'h00, hb: 1'b1, vb: 1'b1, hs: 1'b0, vs: 1'b0};

    logic [15:0] pal [4096];
    pix_t        vq[$];
    logic [15:0] cq[$];
    logic [15:0] exp_dout = '0;
    pix_t        last_exp = RST_EXP;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int scale5(input int v);
        return v * 8 + v / 4;
    endfunction

    function automatic pix_t out_pix();
        return '{r: red, g: green, b: blue, hb: hblank, vb: vblank, hs: hsync, vs: vsync};
    endfunction

    // Reference pixel for the inputs currently applied, using the palette as
    // it stands before this edge's CPU write.
    function automatic pix_t model_pixel();
        int tpen = int'(tile_color[3:0]);
        int open = int'(obj_color[3:0]);
        int tcol, ocol, idx, w;
        pix_t p;
`ifdef MIXER_DBG_EN
        if (!dbg_en[0]) tpen = 0;
        if (!dbg_en[1]) open = 0;
`endif
        tcol = int'(tile_color[9:4]) * 16 + tpen;
        ocol = int'(obj_color[9:4]) * 16 + open;
        if (tile_prio && tpen != 0)  idx = int'(pal_bank) * 2048 + tcol;
        else if (open != 0)          idx = int'(pal_bank) * 2048 + 1024 + ocol;
        else                         idx = int'(pal_bank) * 2048 + tcol;
        w = int'(pal[idx]);
        p.hb = hblank_in; p.vb = vblank_in; p.hs = hsync_in; p.vs = vsync_in;
        if (hblank_in || vblank_in) begin
            p.r = 8'd0; p.g = 8'd0; p.b = 8'd0;
        end else begin
            p.r = 8'(scale5(w % 32));
            p.g = 8'(scale5((w / 32) % 32));
            p.b = 8'(scale5((w / 1024) % 32));
        end
        return p;
    endfunction

    // Called with inputs applied; records expectations for the coming edge.
    task automatic tick();
        int ca = int'(pal_bank) * 2048 + int'(cpu_addr);
        if (reset) begin
            vq.delete();
            vq.push_back(RST_EXP);
            cq.delete();
            exp_dout = '0;
        end else begin
            if (ce_pix) vq.push_back(model_pixel());
            if (cpu_wr || cpu_rd) begin
                if (!cpu_wr) exp_dout = pal[ca];
                cq.push_back(exp_dout);
            end
        end
        if (cpu_wr) pal[ca] = cpu_din;
        @(negedge clk);
    endtask

    task automatic cpu_access(input logic bank, input logic [10:0] a, input logic [15:0] d,
                              input logic wr, input logic rd);
        pal_bank = bank; cpu_addr = a; cpu_din = d; cpu_wr = wr; cpu_rd = rd;
        tick();
        cpu_wr = 1'b0; cpu_rd = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a pixel or an ack.
    initial begin
        logic s_rst, s_ce;
        forever begin
            @(posedge clk);
            s_rst = reset;
            s_ce  = ce_pix;
            #1;
            if (s_rst) begin
                chk("reset_video", 64'(out_pix()), 64'(RST_EXP));
                last_exp = RST_EXP;
            end else if (s_ce) begin
                if (vq.size() >= 2) begin
                    last_exp = vq.pop_front();
                    chk("pixel", 64'(out_pix()), 64'(last_exp));
                end else begin
                    chk("video_queue_depth", 64'(vq.size()), 64'd2);
                end
            end else begin
                chk("pixel_hold", 64'(out_pix()), 64'(last_exp));
            end
            chk("cpu_ack", 64'(cpu_ack), 64'(cq.size() != 0));
            if (cq.size() != 0) chk("cpu_dout_ack", 64'(cpu_dout), 64'(cq.pop_front()));
            chk("cpu_dout_hold", 64'(cpu_dout), 64'(exp_dout));
        end
    end

    initial begin
        vq.push_back(RST_EXP);
        tick();
        tick();
        reset = 1'b0;
        chk("reset_outputs", {red, green, blue, hblank, vblank, hsync, vsync, cpu_ack, cpu_dout},
            {24'h0, 4'b1100, 1'b0, 16'h0});

        // Fill the whole palette back-to-back (one access per clk).
        for (int i = 0; i < 4096; i++) begin
            cpu_access(i[11], i[10:0], 16'($urandom), 1'b1, 1'b0);
        end

        cpu_access(1'b0, 11'h123, 16'h7FFF, 1'b1, 1'b0);
        chk("write_ack", 64'(cpu_ack), 64'd1);
        cpu_access(1'b0, 11'h123, 16'h0000, 1'b0, 1'b1);
        chk("readback", 64'({cpu_ack, cpu_dout}), 64'({1'b1, 16'h7FFF}));
        cpu_access(1'b0, 11'h0A5, 16'h001F, 1'b1, 1'b0);
        cpu_access(1'b0, 11'h413, 16'h7C00, 1'b1, 1'b0);

        pal_bank = 1'b0; ce_pix = 1'b1;
        tile_color = 11'h0A5; tile_prio = 1'b0; obj_color = 11'h000;
        tick(); tick();
        chk("tile_red", 64'({red, green, blue}), 64'(24'hFF0000));
        obj_color = 11'h013;
        tick(); tick();
        chk("sprite_blue", 64'({red, green, blue}), 64'(24'h0000FF));
        tile_prio = 1'b1;
        tick(); tick();
        chk("prio_tile_red", 64'({red, green, blue}), 64'(24'hFF0000));

        hblank_in = 1'b1; tick();
        hblank_in = 1'b0; tick();
        chk("hblank_pixel", 64'({hblank, red, green, blue}), 64'({1'b1, 24'h0}));
        tick();
        chk("after_hblank", 64'({hblank, red}), 64'({1'b0, 8'hFF}));

        ce_pix = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) cpu_access(1'b0, 11'h0A5, 16'h03E0, 1'b1, 1'b0);
            else tick();
            chk("frozen", 64'({red, green, blue}), 64'(24'hFF0000));
        end
        ce_pix = 1'b1;
        tick(); tick();
        chk("resume_green", 64'({red, green, blue}), 64'(24'h00FF00));

`ifdef MIXER_DBG_EN
        dbg_en = 2'b01; tile_prio = 1'b0;
        tick(); tick();
        chk("dbg_sprite_off", 64'({red, green, blue}), 64'(24'h00FF00));
        dbg_en = 2'b11;
`endif

        for (int n = 0; n < 3000; n++) begin
            int r;
            reset      = (n == 1500);
            ce_pix     = ($urandom_range(0, 9) < 7);
            tile_color = 11'($urandom);
            obj_color  = 11'($urandom);
            if ($urandom_range(0, 3) == 0) tile_color[3:0] = 4'd0;
            if ($urandom_range(0, 2) == 0) obj_color[3:0] = 4'd0;
            tile_prio  = 1'($urandom);
            pal_bank   = 1'($urandom);
            hblank_in  = ($urandom_range(0, 15) == 0);
            vblank_in  = ($urandom_range(0, 31) == 0);
            hsync_in   = 1'($urandom);
            vsync_in   = 1'($urandom);
            dbg_en     = 2'($urandom);
            r          = int'($urandom_range(0, 7));
            cpu_wr     = !reset && (r == 0 || r == 2);
            cpu_rd     = !reset && (r == 1 || r == 2);
            cpu_addr   = 11'($urandom);
            if ($urandom_range(0, 3) == 0) cpu_addr = {1'b0, tile_color[9:0]};
            cpu_din    = 16'($urandom);
            tick();
            if (n == 1500) chk("midline_reset", 64'({red, green, blue, hblank}), 64'({24'h0, 1'b1}));
        end

        reset = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0; ce_pix = 1'b0;
        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
